// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the shared-memory-port arbiter and its two requesters.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface mem_port_arbiter_if;
  logic req_a;
  logic req_b;
  logic we_b;
  logic sel;
  logic mem_en;
  logic mem_we;
  logic ack_a;
  logic ack_b;
  logic busy;
  logic stall_a;
  logic stall_b;

  modport slave (
    input  req_a, req_b, we_b,
    output sel, mem_en, mem_we, ack_a, ack_b, busy, stall_a, stall_b
  );

  modport master (
    output req_a, req_b, we_b,
    input  sel, mem_en, mem_we, ack_a, ack_b, busy, stall_a, stall_b
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch (A) and data access (B).
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority B over A.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  grant_e     last_grant_q, last_grant_d;
  grant_e     sel_q, sel_d;
  logic       mem_en_q, mem_en_d;
  logic       mem_we_q, mem_we_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       busy_q, busy_d;

  logic       elig_a, elig_b, grant;
  grant_e     winner;

  // In DONE, sel_q still names the requester just served; it sits out this round.
  assign elig_a = bus.req_a & ~((state_q == ST_DONE) && (sel_q == GRANT_A));
  assign elig_b = bus.req_b & ~((state_q == ST_DONE) && (sel_q == GRANT_B));

  always_comb begin
`ifdef ARB_RR_EN
    if (elig_a && elig_b)
      winner = (last_grant_q == GRANT_A) ? GRANT_B : GRANT_A;
    else
      winner = elig_b ? GRANT_B : GRANT_A;
`else
    winner = elig_b ? GRANT_B : GRANT_A;
`endif
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    grant        = 1'b0;

    unique case (state_q)
      ST_IDLE: grant = elig_a | elig_b;
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          ack_a_d = (sel_q == GRANT_A);
          ack_b_d = (sel_q == GRANT_B);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        grant = elig_a | elig_b;
        if (!grant) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d      = ST_BUSY;
      sel_d        = winner;
      mem_en_d     = 1'b1;
      mem_we_d     = (winner == GRANT_B) & bus.we_b;
      busy_d       = 1'b1;
      cnt_d        = CNT_LOAD;
      last_grant_d = winner;
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block with non-blocking updates.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= GRANT_B;
      sel_q        <= GRANT_A;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.mem_en  = mem_en_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.ack_a   = ack_a_q;
  assign bus.ack_b   = ack_b_q;
  assign bus.busy    = busy_q;
  assign bus.stall_a = bus.req_a & ~ack_a_q;
  assign bus.stall_b = bus.req_b & ~ack_b_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LATENCY=2; outputs are packed as
// {sel, mem_en, mem_we, ack_a, ack_b, busy} and sampled 1 ns after each rising edge.
module tb_mem_port_arbiter;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.LATENCY(2)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

`ifdef ARB_RR_EN
  localparam logic FIRST_SEL = 1'b0;
`else
  localparam logic FIRST_SEL = 1'b1;
`endif

  function automatic logic [5:0] outs();
    return {bus.sel, bus.mem_en, bus.mem_we, bus.ack_a, bus.ack_b, bus.busy};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_a = 1'b1; bus.req_b = 1'b1; bus.we_b = 1'b1; Reset_n = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if (outs() !== 6'b000000) begin
        errors++; $display("FAIL reset_outs c%0d: got %b want %b", c, outs(), 6'b000000);
      end
      checks++;
      if ({bus.stall_a, bus.stall_b} !== 2'b11) begin
        errors++; $display("FAIL reset_stall c%0d: got %b want 11", c, {bus.stall_a, bus.stall_b});
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.we_b = 1'b0; Reset_n = 1'b1;
    tick();
    checks++;
    if (outs() !== 6'b000000) begin
      errors++; $display("FAIL reset_release_idle: got %b want 000000", outs());
    end
  endtask

  task automatic test_single_a();
    logic [5:0] exp [4] = '{6'b010001, 6'b000001, 6'b000101, 6'b000000};
    bus.req_a = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (outs() !== exp[c-1]) begin
        errors++; $display("FAIL single_a c%0d: got %b want %b", c, outs(), exp[c-1]);
      end
      if (c == 1 || c == 3) begin
        checks++;
        if (bus.stall_a !== (c == 1)) begin
          errors++; $display("FAIL single_a_stall c%0d: got %b want %b", c, bus.stall_a, c == 1);
        end
      end
      if (c == 3) bus.req_a = 1'b0;
    end
  endtask

  task automatic test_priority();
    logic [5:0] exp [7] = '{6'b111001, 6'b100001, 6'b100011,
                            6'b010001, 6'b000001, 6'b000101, 6'b000000};
    bus.req_a = 1'b1; bus.req_b = 1'b1; bus.we_b = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.we_b = 1'b0;
      checks++;
      if (outs() !== exp[c-1]) begin
        errors++; $display("FAIL priority c%0d: got %b want %b", c, outs(), exp[c-1]);
      end
      if (c == 3) begin
        checks++;
        if ({bus.stall_a, bus.stall_b} !== 2'b10) begin
          errors++; $display("FAIL priority_stall c3: got %b want 10", {bus.stall_a, bus.stall_b});
        end
        bus.req_b = 1'b0;
      end
      if (c == 6) bus.req_a = 1'b0;
    end
  endtask

  task automatic test_alternate();
    logic [5:0] e;
    logic       s;
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1; bus.req_a = 1'b1; bus.req_b = 1'b1; bus.we_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      s = FIRST_SEL ^ 1'(((c - 1) / 3) % 2);
      case ((c - 1) % 3)
        0:       e = {s, 5'b10001};
        1:       e = {s, 5'b00001};
        default: e = s ? 6'b100011 : 6'b000101;
      endcase
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL alternate c%0d: got %b want %b", c, outs(), e);
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();
    checks++;
    if (outs() !== {~FIRST_SEL, 5'b00000}) begin
      errors++; $display("FAIL alternate_idle: got %b want %b", outs(), {~FIRST_SEL, 5'b00000});
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp [7] = '{6'b010001, 6'b000001, 6'b000000,
                            6'b010001, 6'b000001, 6'b000101, 6'b000000};
    bus.req_a = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (outs() !== exp[c-1]) begin
        errors++; $display("FAIL reset_mid c%0d: got %b want %b", c, outs(), exp[c-1]);
      end
      if (c == 2) Reset_n = 1'b0;
      if (c == 3) Reset_n = 1'b1;
      if (c == 6) bus.req_a = 1'b0;
    end
  endtask

  task automatic test_drop_b();
    logic [5:0] exp [5] = '{6'b110001, 6'b100001, 6'b100011, 6'b100000, 6'b100000};
    bus.req_b = 1'b1; bus.we_b = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (outs() !== exp[c-1]) begin
        errors++; $display("FAIL drop_b c%0d: got %b want %b", c, outs(), exp[c-1]);
      end
      if (c == 2) begin
        bus.req_b = 1'b0;
        #1;
        checks++;
        if (bus.stall_b !== 1'b0) begin
          errors++; $display("FAIL drop_b_stall: got %b want 0", bus.stall_b);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.we_b = 1'b0;
    test_reset();
    test_single_a();
    test_priority();
    test_alternate();
    test_reset_mid();
    test_drop_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
